// File: rtl/dma_io_device.sv
// Single-channel DMA slave I/O device: TX/RX FIFOs toward a local port and a
// DREQ/DACK handshake with IOR_N/IOW_N strobes toward the system bus.
module dma_io_device #(
  parameter int DEPTH = 8,
  parameter int DW    = 8
) (
  input  logic                      CLK,
  input  logic                      RESET_N,
  input  logic                      ENABLE,
  input  logic                      DIR,
  input  logic                      DEMAND,
  output logic                      DREQ,
  input  logic                      DACK,
  input  logic                      EOP_N,
  input  logic                      IOR_N,
  input  logic                      IOW_N,
  input  logic [DW-1:0]             DB_IN,
  output logic [DW-1:0]             DB_OUT,
  output logic                      DB_OE,
  input  logic                      devPush,
  input  logic [DW-1:0]             devData,
  input  logic                      devPop,
  output logic [DW-1:0]             devDataOut,
  output logic [$clog2(DEPTH):0]    txCount,
  output logic [$clog2(DEPTH):0]    rxCount,
  output logic                      tcFlag,
  output logic                      underrunFlag,
  output logic                      overrunFlag,
  output logic                      protocolErr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            dreq_q;
  logic [DW-1:0]   tx_mem [DEPTH];
  logic [DW-1:0]   rx_mem [DEPTH];
  logic [AW-1:0]   tx_rd_q, tx_wr_q, rx_rd_q, rx_wr_q;
  logic [CW-1:0]   tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic            ior_low_q, iow_low_q, err_xfer_q, err_xfer_d;
  logic [DW-1:0]   cap_q, cap_d;
  logic            tc_q, tc_d, under_q, under_d, over_q, over_d, perr_q, perr_d;

  logic            cmpl_s, ior_cmpl_s, iow_cmpl_s, both_low_s;
  logic            tx_push_s, tx_pop_s, rx_push_s, rx_pop_s;
  logic            tx_ready_s, rx_ready_s, ready_after_s;

  // Strobe completion detect, FIFO handshakes and sticky flag next-state.
  always_comb begin
    both_low_s = DACK & ~IOR_N & ~IOW_N;
    cmpl_s     = (state_q == ACK) & ~err_xfer_q &
                 (DIR ? (ior_low_q & IOR_N) : (iow_low_q & IOW_N));
    ior_cmpl_s = cmpl_s & DIR;
    iow_cmpl_s = cmpl_s & ~DIR;

    tx_push_s  = devPush & (tx_cnt_q != FULL);
    tx_pop_s   = ior_cmpl_s & (tx_cnt_q != '0);
    rx_push_s  = iow_cmpl_s & (rx_cnt_q != FULL);
    rx_pop_s   = devPop & (rx_cnt_q != '0);

    tx_cnt_d   = tx_cnt_q + CW'(tx_push_s) - CW'(tx_pop_s);
    rx_cnt_d   = rx_cnt_q + CW'(rx_push_s) - CW'(rx_pop_s);

    tx_ready_s    = DIR & (tx_cnt_q != '0);
    rx_ready_s    = ~DIR & (rx_cnt_q != FULL);
    ready_after_s = DIR ? (tx_cnt_d != '0) : (rx_cnt_d != FULL);

    // A transfer tainted by both strobes stays ignored until both go high.
    if (both_low_s) begin
      err_xfer_d = 1'b1;
    end else if (IOR_N && IOW_N) begin
      err_xfer_d = 1'b0;
    end else begin
      err_xfer_d = err_xfer_q;
    end

    cap_d = (DACK && !IOW_N) ? DB_IN : cap_q;

    if (!ENABLE) begin
      tc_d    = 1'b0;
      under_d = 1'b0;
      over_d  = 1'b0;
      perr_d  = 1'b0;
    end else begin
      tc_d    = tc_q | (~EOP_N & (state_q != IDLE));
      under_d = under_q | (ior_cmpl_s & (tx_cnt_q == '0));
      over_d  = over_q | (iow_cmpl_s & (rx_cnt_q == FULL));
      perr_d  = perr_q | both_low_s;
    end
  end

  // Request/acknowledge state machine next-state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (ENABLE && !tc_q && (tx_ready_s || rx_ready_s)) state_d = REQ;
        else state_d = IDLE;
      end
      REQ: begin
        if (!EOP_N) state_d = IDLE;
        else if (DACK) state_d = ACK;
        else state_d = REQ;
      end
      ACK: begin
        if (!EOP_N) state_d = IDLE;
        else if (cmpl_s) state_d = (DEMAND && ready_after_s) ? ACK : IDLE;
        else state_d = ACK;
      end
      default: state_d = IDLE;
    endcase
    if (!ENABLE) begin
      state_d = IDLE;
    end else begin
      state_d = state_d;
    end
  end

  // Control, pointer, count and flag registers.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q    <= IDLE;
      dreq_q     <= 1'b0;
      tx_rd_q    <= '0;
      tx_wr_q    <= '0;
      rx_rd_q    <= '0;
      rx_wr_q    <= '0;
      tx_cnt_q   <= '0;
      rx_cnt_q   <= '0;
      ior_low_q  <= 1'b0;
      iow_low_q  <= 1'b0;
      err_xfer_q <= 1'b0;
      cap_q      <= '0;
      tc_q       <= 1'b0;
      under_q    <= 1'b0;
      over_q     <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dreq_q     <= (state_d != IDLE);
      if (tx_push_s) tx_wr_q <= tx_wr_q + AW'(1);
      if (tx_pop_s)  tx_rd_q <= tx_rd_q + AW'(1);
      if (rx_push_s) rx_wr_q <= rx_wr_q + AW'(1);
      if (rx_pop_s)  rx_rd_q <= rx_rd_q + AW'(1);
      tx_cnt_q   <= tx_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
      ior_low_q  <= DACK & ~IOR_N;
      iow_low_q  <= DACK & ~IOW_N;
      err_xfer_q <= err_xfer_d;
      cap_q      <= cap_d;
      tc_q       <= tc_d;
      under_q    <= under_d;
      over_q     <= over_d;
      perr_q     <= perr_d;
    end
  end

  // FIFO storage; writes are suppressed while reset is asserted.
  always_ff @(posedge CLK) begin
    if (RESET_N && tx_push_s) tx_mem[tx_wr_q] <= devData;
    if (RESET_N && rx_push_s) rx_mem[rx_wr_q] <= cap_q;
  end

  assign DREQ         = dreq_q;
  assign DB_OE        = DACK & ~IOR_N & DIR;
  assign DB_OUT       = (DB_OE && tx_cnt_q != '0) ? tx_mem[tx_rd_q] : '0;
  assign devDataOut   = (rx_cnt_q != '0) ? rx_mem[rx_rd_q] : '0;
  assign txCount      = tx_cnt_q;
  assign rxCount      = rx_cnt_q;
  assign tcFlag       = tc_q;
  assign underrunFlag = under_q;
  assign overrunFlag  = over_q;
  assign protocolErr  = perr_q;

endmodule

// File: tb/tb_dma_io_device.sv
// Directed self-checking bench for dma_io_device (DEPTH=8, DW=8).
module tb_dma_io_device;
  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0, ENABLE = 1'b0, DIR = 1'b0, DEMAND = 1'b0;
  logic       DACK = 1'b0, EOP_N = 1'b1, IOR_N = 1'b1, IOW_N = 1'b1;
  logic [7:0] DB_IN = 8'h00, devData = 8'h00;
  logic       devPush = 1'b0, devPop = 1'b0;
  logic       DREQ, DB_OE, tcFlag, underrunFlag, overrunFlag, protocolErr;
  logic [7:0] DB_OUT, devDataOut;
  logic [3:0] txCount, rxCount;
  int         n_assert = 0;
  int         n_fail = 0;

  dma_io_device #(.DEPTH(8), .DW(8)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .ENABLE(ENABLE), .DIR(DIR), .DEMAND(DEMAND),
    .DREQ(DREQ), .DACK(DACK), .EOP_N(EOP_N), .IOR_N(IOR_N), .IOW_N(IOW_N),
    .DB_IN(DB_IN), .DB_OUT(DB_OUT), .DB_OE(DB_OE), .devPush(devPush),
    .devData(devData), .devPop(devPop), .devDataOut(devDataOut),
    .txCount(txCount), .rxCount(rxCount), .tcFlag(tcFlag),
    .underrunFlag(underrunFlag), .overrunFlag(overrunFlag), .protocolErr(protocolErr)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_dreq(input string tag);
    for (int k = 0; k < 4 && DREQ !== 1'b1; k++) tick();
    chk(tag, 32'(DREQ), 32'd1);
  endtask

  task automatic iow(input logic [7:0] d);
    DB_IN = d;
    IOW_N = 1'b0;
    tick();
    IOW_N = 1'b1;
    DB_IN = 8'h00;
    tick();
  endtask

  initial begin
    tick(); tick();
    chk("rst_dreq", 32'(DREQ), 32'd0);
    chk("rst_txcnt", 32'(txCount), 32'd0);
    chk("rst_rxcnt", 32'(rxCount), 32'd0);
    chk("rst_flags", {28'd0, tcFlag, underrunFlag, overrunFlag, protocolErr}, 32'd0);
    chk("rst_dbout", 32'(DB_OUT), 32'd0);
    RESET_N = 1'b1;

    // Single-mode IOR of one byte
    ENABLE = 1'b1; DIR = 1'b1; DEMAND = 1'b0;
    devPush = 1'b1; devData = 8'hA5; tick(); devPush = 1'b0;
    chk("push_txcnt", 32'(txCount), 32'd1);
    wait_dreq("single_dreq");
    DACK = 1'b1; IOR_N = 1'b0; tick(); tick();
    chk("single_dbout", 32'(DB_OUT), 32'hA5);
    chk("single_dboe", 32'(DB_OE), 32'd1);
    IOR_N = 1'b1; tick();
    chk("single_txcnt", 32'(txCount), 32'd0);
    chk("single_dreq_low", 32'(DREQ), 32'd0);
    DACK = 1'b0;
    chk("dboe_nodack", 32'(DB_OE), 32'd0);

    // Demand-mode IOW of three bytes
    DIR = 1'b0; DEMAND = 1'b1;
    wait_dreq("demand_dreq");
    DACK = 1'b1;
    iow(8'h11); chk("demand_dreq1", 32'(DREQ), 32'd1);
    iow(8'h22); chk("demand_dreq2", 32'(DREQ), 32'd1);
    iow(8'h33); chk("demand_dreq3", 32'(DREQ), 32'd1);
    DACK = 1'b0; ENABLE = 1'b0; tick();
    chk("rx_cnt3", 32'(rxCount), 32'd3);
    chk("rx_head0", 32'(devDataOut), 32'h11);
    devPop = 1'b1; tick();
    chk("rx_head1", 32'(devDataOut), 32'h22);
    tick();
    chk("rx_head2", 32'(devDataOut), 32'h33);
    tick(); tick();
    devPop = 1'b0;
    chk("rx_empty_cnt", 32'(rxCount), 32'd0);
    chk("rx_empty_data", 32'(devDataOut), 32'h00);

    // Boundaries: RX full via demand writes, TX full plus one dropped push
    ENABLE = 1'b1;
    wait_dreq("fill_dreq");
    DACK = 1'b1;
    for (int i = 0; i < 8; i++) iow(8'h40 + 8'(i));
    DACK = 1'b0;
    chk("rx_full_cnt", 32'(rxCount), 32'd8);
    chk("rx_full_dreq", 32'(DREQ), 32'd0);
    for (int i = 0; i < 9; i++) begin
      devPush = 1'b1; devData = (i == 8) ? 8'hFF : 8'hB0 + 8'(i); tick();
    end
    devPush = 1'b0;
    chk("tx_full_cnt", 32'(txCount), 32'd8);
    DIR = 1'b1; DEMAND = 1'b0;
    wait_dreq("ovr_dreq");
    DACK = 1'b1; tick();
    DIR = 1'b0;
    iow(8'h99);
    chk("ovr_flag", 32'(overrunFlag), 32'd1);
    chk("ovr_rxcnt", 32'(rxCount), 32'd8);
    chk("ovr_head", 32'(devDataOut), 32'h40);
    DACK = 1'b0; ENABLE = 1'b0; tick();
    chk("ovr_clear", 32'(overrunFlag), 32'd0);
    chk("keep_rxcnt", 32'(rxCount), 32'd8);

    // EOP during second demand-mode IOR
    ENABLE = 1'b1; DIR = 1'b1; DEMAND = 1'b1;
    wait_dreq("eop_dreq");
    DACK = 1'b1; IOR_N = 1'b0; tick();
    chk("eop_db0", 32'(DB_OUT), 32'hB0);
    IOR_N = 1'b1; tick();
    chk("eop_dreq_mid", 32'(DREQ), 32'd1);
    chk("eop_txcnt1", 32'(txCount), 32'd7);
    IOR_N = 1'b0; tick();
    chk("eop_db1", 32'(DB_OUT), 32'hB1);
    EOP_N = 1'b0; IOR_N = 1'b1; tick();
    EOP_N = 1'b1; DACK = 1'b0;
    chk("eop_txcnt2", 32'(txCount), 32'd6);
    chk("eop_tc", 32'(tcFlag), 32'd1);
    chk("eop_dreq0", 32'(DREQ), 32'd0);
    tick(); tick(); tick();
    chk("eop_noreq", 32'(DREQ), 32'd0);
    ENABLE = 1'b0; tick();
    chk("tc_clear", 32'(tcFlag), 32'd0);
    ENABLE = 1'b1;
    wait_dreq("reenable_dreq");

    // Both strobes low, then reset in the middle of ACK
    DACK = 1'b1; IOR_N = 1'b0; IOW_N = 1'b0; tick();
    chk("perr_flag", 32'(protocolErr), 32'd1);
    IOR_N = 1'b1; IOW_N = 1'b1; tick();
    chk("perr_txcnt", 32'(txCount), 32'd6);
    chk("perr_rxcnt", 32'(rxCount), 32'd8);
    IOR_N = 1'b0; tick();
    chk("perr_db2", 32'(DB_OUT), 32'hB2);
    RESET_N = 1'b0; tick();
    chk("mid_rst_dreq", 32'(DREQ), 32'd0);
    chk("mid_rst_txcnt", 32'(txCount), 32'd0);
    chk("mid_rst_rxcnt", 32'(rxCount), 32'd0);
    chk("mid_rst_flags", {28'd0, tcFlag, underrunFlag, overrunFlag, protocolErr}, 32'd0);
    chk("mid_rst_dout", 32'(devDataOut), 32'h00);
    chk("mid_rst_dbout", 32'(DB_OUT), 32'h00);
    DACK = 1'b0; IOR_N = 1'b1; #1;
    chk("mid_rst_dboe", 32'(DB_OE), 32'd0);
    RESET_N = 1'b1;

    // IOR with TX empty
    ENABLE = 1'b1; DIR = 1'b0; DEMAND = 1'b0;
    wait_dreq("und_dreq");
    DACK = 1'b1; tick();
    DIR = 1'b1; IOR_N = 1'b0; tick();
    chk("und_dbout", 32'(DB_OUT), 32'h00);
    IOR_N = 1'b1; tick();
    chk("und_flag", 32'(underrunFlag), 32'd1);
    chk("und_txcnt", 32'(txCount), 32'd0);
    chk("und_dreq", 32'(DREQ), 32'd0);
    DACK = 1'b0; tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
